addsub_serial: RTL and testbench

Parametrised multi-cycle add/subtract unit, the sequential successor to the 8-bit ripple-borrow full subtractor. Operands are captured through a valid/ready handshake and processed in CHUNK-bit slices, LSB first, one slice per clock, with the carry/borrow held in a register between slices. Used wherever a narrow, area-cheap wide-word arithmetic datapath is preferred over a single-cycle ripple chain.

---
 rtl/addsub_serial.sv | 137 +++++++++++++
 tb/tb_addsub_serial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial -- multi-cycle add/subtract unit.
//
// Operands are captured on a valid/ready handshake and processed CHUNK bits
// per clock, LSB slice first, with the carry (add) or borrow (subtract) held
// in a register between slices. The finished result is held in DONE until
// downstream accepts it.
//
// Parameters:
//   WIDTH      operand/result width (>= 2)
//   CHUNK      bits per slice; must divide WIDTH
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   unit idle and able to accept operands
//   mode       0 = x - y - cb_in, 1 = x + y + cb_in (captured on accept)
//   cb_in      borrow-in / carry-in (captured on accept)
//   x, y       operands (captured on accept)
//   out_valid  result fields valid
//   out_ready  downstream accepts result
//   result     sum/difference modulo 2^WIDTH
//   cb_out     final borrow-out / carry-out
//   ovf        two's-complement signed overflow
//   zero       result == 0
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic             cb_in,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cb_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int CW     = CHUNK + 1;

   if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] x_r, y_r;
   logic             mode_r;
   logic             x_msb, y_msb;
   logic [IW-1:0]    idx;
   logic             last;
   logic [CHUNK:0]   slice;
   logic [WIDTH-1:0] res_nxt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Operand registers shift right each slice, so the current slice is always
   // in the low CHUNK bits. cb_out doubles as the running carry/borrow. In the
   // subtract case the CW-bit difference goes negative exactly when a borrow
   // is taken, so its top bit is the borrow.
   always_comb begin
      if (mode_r)
         slice = {1'b0, x_r[CHUNK-1:0]} + {1'b0, y_r[CHUNK-1:0]} + CW'(cb_out);
      else
         slice = {1'b0, x_r[CHUNK-1:0]} - {1'b0, y_r[CHUNK-1:0]} - CW'(cb_out);
      // Result fills from the top; after NSLICE slices slice 0 sits at the LSBs.
      res_nxt = (result >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
      last    = (idx == IW'(NSLICE - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_r    <= '0;
         y_r    <= '0;
         mode_r <= 1'b0;
         x_msb  <= 1'b0;
         y_msb  <= 1'b0;
         idx    <= '0;
         result <= '0;
         cb_out <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x_r    <= x;
               y_r    <= y;
               mode_r <= mode;
               x_msb  <= x[WIDTH-1];
               y_msb  <= y[WIDTH-1];
               cb_out <= cb_in;
               idx    <= '0;
            end
            CALC: begin
               x_r    <= x_r >> CHUNK;
               y_r    <= y_r >> CHUNK;
               result <= res_nxt;
               cb_out <= slice[CHUNK];
               idx    <= idx + IW'(1);
               // Flags need the complete result, so they are set on the final slice.
               if (last) begin
                  zero <= (res_nxt == '0);
                  if (mode_r) ovf <= (x_msb == y_msb) && (res_nxt[WIDTH-1] != x_msb);
                  else        ovf <= (x_msb != y_msb) && (res_nxt[WIDTH-1] != x_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial -- self-checking bench for addsub_serial.
// Five instances: WIDTH=8 with CHUNK 1/2/4/8 (index 0..3) and WIDTH=16 with
// CHUNK 4 (index 4). Results are compared against a plain-arithmetic model.
module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  iv = '0;
   logic        mode = 1'b0, cbi = 1'b0, ordy = 1'b1;
   logic [15:0] xi = '0, yi = '0;
   logic [4:0]  ir, ov, cbo, ovo, zo;
   logic [7:0]  r0, r1, r2, r3;
   logic [15:0] r4;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(8), .CHUNK(1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .mode(mode), .cb_in(cbi), .x(xi[7:0]), .y(yi[7:0]), .out_valid(ov[0]), .out_ready(ordy),
      .result(r0), .cb_out(cbo[0]), .ovf(ovo[0]), .zero(zo[0]));
   addsub_serial #(.WIDTH(8), .CHUNK(2)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .mode(mode), .cb_in(cbi), .x(xi[7:0]), .y(yi[7:0]), .out_valid(ov[1]), .out_ready(ordy),
      .result(r1), .cb_out(cbo[1]), .ovf(ovo[1]), .zero(zo[1]));
   addsub_serial #(.WIDTH(8), .CHUNK(4)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .mode(mode), .cb_in(cbi), .x(xi[7:0]), .y(yi[7:0]), .out_valid(ov[2]), .out_ready(ordy),
      .result(r2), .cb_out(cbo[2]), .ovf(ovo[2]), .zero(zo[2]));
   addsub_serial #(.WIDTH(8), .CHUNK(8)) u3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
      .mode(mode), .cb_in(cbi), .x(xi[7:0]), .y(yi[7:0]), .out_valid(ov[3]), .out_ready(ordy),
      .result(r3), .cb_out(cbo[3]), .ovf(ovo[3]), .zero(zo[3]));
   addsub_serial #(.WIDTH(16), .CHUNK(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
      .mode(mode), .cb_in(cbi), .x(xi), .y(yi), .out_valid(ov[4]), .out_ready(ordy),
      .result(r4), .cb_out(cbo[4]), .ovf(ovo[4]), .zero(zo[4]));

   function automatic logic [15:0] get_res(input int d);
      case (d)
         0:       return {8'h00, r0};
         1:       return {8'h00, r1};
         2:       return {8'h00, r2};
         3:       return {8'h00, r3};
         default: return r4;
      endcase
   endfunction

   function automatic int nsl(input int d);
      case (d)
         0:       return 8;
         1:       return 4;
         2:       return 2;
         3:       return 1;
         default: return 4;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic on wide integers.
   task automatic model(input int w, input logic m, input logic c, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic co, output logic ovf_e, output logic z);
      longint la, lb, lc, full, mask;
      logic ax, bx, rm;
      la = longint'(a); lb = longint'(b); lc = longint'(c);
      mask = (longint'(1) << w) - 1;
      if (m) begin
         full = la + lb + lc;
         r    = 16'(full & mask);
         co   = ((full >> w) & 1) != 0;
      end else begin
         full = la - lb - lc;
         r    = 16'(full & mask);
         co   = la < (lb + lc);
      end
      ax = a[w-1]; bx = b[w-1]; rm = r[w-1];
      ovf_e = m ? ((ax == bx) && (rm != ax)) : ((ax != bx) && (rm != ax));
      z = (r == 16'h0000);
   endtask

   // One full transaction on instance d; returns the observed result.
   task automatic do_op(input int d, input logic m, input logic c, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r_o);
      int n;
      int w;
      logic [15:0] er;
      logic ec, eo, ez;
      w = (d == 4) ? 16 : 8;
      model(w, m, c, a, b, er, ec, eo, ez);
      chk("in_ready_before_accept", 32'(ir[d]), 32'd1);
      iv[d] = 1'b1; mode = m; cbi = c; xi = a; yi = b;
      tick;
      iv[d] = 1'b0;
      // operands must be ignored once captured
      xi = 16'($urandom); yi = 16'($urandom); mode = ~m; cbi = ~c;
      n = 0;
      while (!ov[d] && n < 200) begin
         tick;
         n++;
      end
      chk("latency_edges", 32'(n), 32'(nsl(d)));
      chk("result", 32'(get_res(d)), 32'(er));
      chk("cb_out", 32'(cbo[d]), 32'(ec));
      chk("ovf", 32'(ovo[d]), 32'(eo));
      chk("zero", 32'(zo[d]), 32'(ez));
      r_o = get_res(d);
      if (ordy) tick;
   endtask

   logic [15:0] rr, hold_r;
   logic        hold_c, hold_o, hold_z;
   logic        seen;

   initial begin
      // reset state
      tick; tick;
      for (int d = 0; d < 5; d++) begin
         chk("rst_in_ready", 32'(ir[d]), 32'd1);
         chk("rst_out_valid", 32'(ov[d]), 32'd0);
         chk("rst_result", 32'(get_res(d)), 32'd0);
         chk("rst_flags", {29'd0, cbo[d], ovo[d], zo[d]}, 32'd0);
      end
      rst = 1'b0;
      tick;

      // back-to-back subtracts, W8 C1
      do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h0000, rr); chk("FF-00", 32'(rr), 32'h00FF);
      do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h00FF, rr); chk("FF-FF", 32'(rr), 32'h0000);
      do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h00A2, rr); chk("FF-A2", 32'(rr), 32'h005D);
      do_op(0, 1'b0, 1'b0, 16'h00F1, 16'h0011, rr); chk("F1-11", 32'(rr), 32'h00E0);
      do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h00BC, rr); chk("FF-BC", 32'(rr), 32'h0043);
      // borrow / overflow corners
      do_op(0, 1'b0, 1'b0, 16'h0011, 16'h00FF, rr); chk("11-FF", {rr, 15'd0, cbo[0]}, {16'h0012, 16'd1});
      do_op(0, 1'b0, 1'b0, 16'h0000, 16'h00FF, rr); chk("00-FF", {rr, 15'd0, cbo[0]}, {16'h0001, 16'd1});
      do_op(0, 1'b0, 1'b0, 16'h000F, 16'h00F1, rr); chk("0F-F1", {rr, 14'd0, cbo[0], ovo[0]}, {16'h001E, 16'd2});
      do_op(0, 1'b0, 1'b0, 16'h0080, 16'h0001, rr); chk("80-01", {rr, 15'd0, ovo[0]}, {16'h007F, 16'd1});
      do_op(0, 1'b0, 1'b1, 16'h0000, 16'h0000, rr); chk("00-00-1", {rr, 15'd0, cbo[0]}, {16'h00FF, 16'd1});
      // W16 C4 adds
      do_op(4, 1'b1, 1'b0, 16'hFFFF, 16'h0001, rr); chk("FFFF+1", {rr, 14'd0, cbo[4], zo[4]}, {16'h0000, 16'd3});
      do_op(4, 1'b1, 1'b1, 16'h7FFF, 16'h0000, rr); chk("7FFF+0+1", {rr, 15'd0, ovo[4]}, {16'h8000, 16'd1});

      // backpressure: hold DONE for 6 cycles, try a second accept meanwhile
      ordy = 1'b0;
      do_op(0, 1'b0, 1'b0, 16'h00F1, 16'h0011, rr);
      hold_r = get_res(0); hold_c = cbo[0]; hold_o = ovo[0]; hold_z = zo[0];
      for (int i = 0; i < 6; i++) begin
         iv[0] = (i == 2); xi = 16'h0033; yi = 16'h0011;
         tick;
         chk("bp_out_valid", 32'(ov[0]), 32'd1);
         chk("bp_in_ready", 32'(ir[0]), 32'd0);
         chk("bp_hold", {hold_r, 13'd0, cbo[0], ovo[0], zo[0]}, {16'h00E0, 13'd0, hold_c, hold_o, hold_z});
      end
      iv[0] = 1'b0;
      chk("bp_result_held", 32'(get_res(0)), 32'h00E0);
      ordy = 1'b1;
      tick;
      chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
      chk("bp_release_out_valid", 32'(ov[0]), 32'd0);

      // reset in the third CALC cycle
      iv[0] = 1'b1; mode = 1'b0; cbi = 1'b0; xi = 16'h0011; yi = 16'h00FF;
      tick;
      iv[0] = 1'b0;
      tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_in_ready", 32'(ir[0]), 32'd1);
      chk("abort_out_valid", 32'(ov[0]), 32'd0);
      chk("abort_outputs", {get_res(0), 13'd0, cbo[0], ovo[0], zo[0]}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (ov[0]) seen = 1'b1;
      end
      chk("abort_no_output", 32'(seen), 32'd0);
      do_op(0, 1'b0, 1'b0, 16'h00FF, 16'h00A2, rr); chk("post_abort_FF-A2", 32'(rr), 32'h005D);

      // random operands on all WIDTH=8 chunkings
      for (int d = 0; d < 4; d++) begin
         for (int i = 0; i < 250; i++) begin
            do_op(d, 1'($urandom), 1'($urandom), {8'h00, 8'($urandom)}, {8'h00, 8'($urandom)}, rr);
         end
      end
      // a few wide ones too
      for (int i = 0; i < 40; i++) begin
         do_op(4, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
